// File: rtl/vadd_seq_ctrl.sv
// Beat sequencer for the 64-bit packed vector add/sub lane: splits one add-class
// instruction into 64-bit beats, strobes RF reads and drives the writeback handshake.
module vadd_seq_ctrl #(
    parameter int VL_WIDTH    = 8,
    parameter int SEW_WIDTH   = 2,
    parameter int OPSEL_WIDTH = 6,
    parameter int IDX_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPSEL_WIDTH-1:0] in_opsel,
    input  logic [SEW_WIDTH-1:0]   in_sew,
    input  logic [VL_WIDTH-1:0]    in_vl,
    input  logic                   in_carry,
    output logic [OPSEL_WIDTH-1:0] add_opsel,
    output logic [SEW_WIDTH-1:0]   add_sew,
    output logic                   add_carry,
    output logic                   rd_en,
    output logic [IDX_WIDTH-1:0]   rd_idx,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [IDX_WIDTH-1:0]   wb_idx,
    output logic [7:0]             wb_be,
    output logic                   busy,
    output logic                   done
);

    localparam int TB_W = VL_WIDTH + 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_WIDTH-1:0]   issue_cnt_reg;
    logic [IDX_WIDTH-1:0]   beats_reg;
    logic [2:0]             tail_reg;
    logic [OPSEL_WIDTH-1:0] add_opsel_reg;
    logic [SEW_WIDTH-1:0]   add_sew_reg;
    logic                   add_carry_reg;
    logic                   wb_valid_reg;
    logic [IDX_WIDTH-1:0]   wb_idx_reg;
    logic [7:0]             wb_be_reg;

    logic [TB_W-1:0]        total_bytes;
    logic [IDX_WIDTH-1:0]   beats_calc;
    logic [7:0]             tail_mask;
    logic                   accept;
    logic                   issue_ok;
    logic                   last_issue;
    logic                   last_wb_hs;

    // Instruction length in bytes; a partial final beat rounds the beat count up.
    assign total_bytes = TB_W'(in_vl) << in_sew;
    assign beats_calc  = IDX_WIDTH'(total_bytes >> 3) + IDX_WIDTH'(|total_bytes[2:0]);

    for (genvar gi = 0; gi < 8; gi++) begin : g_tail_mask
        assign tail_mask[gi] = (tail_reg > 3'(gi));
    end

    assign accept     = in_valid & in_ready;
    assign issue_ok   = ~wb_valid_reg | wb_ready;
    assign last_issue = (issue_cnt_reg == beats_reg - 1'b1);
    assign last_wb_hs = wb_valid_reg & wb_ready & (wb_idx_reg == beats_reg - 1'b1);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (beats_calc == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = issue_ok & (issue_cnt_reg < beats_reg);
                if (last_wb_hs) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            issue_cnt_reg <= '0;
            beats_reg     <= '0;
            tail_reg      <= '0;
            add_opsel_reg <= '0;
            add_sew_reg   <= '0;
            add_carry_reg <= 1'b0;
            wb_valid_reg  <= 1'b0;
            wb_idx_reg    <= '0;
            wb_be_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                add_opsel_reg <= in_opsel;
                add_sew_reg   <= in_sew;
                add_carry_reg <= in_carry;
                beats_reg     <= beats_calc;
                tail_reg      <= total_bytes[2:0];
                issue_cnt_reg <= '0;
            end
            // A stalled result holds; a fresh issue replaces it in the same cycle it drains.
            if (rd_en) begin
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
                wb_valid_reg  <= 1'b1;
                wb_idx_reg    <= issue_cnt_reg;
                wb_be_reg     <= (last_issue && tail_reg != 3'd0) ? tail_mask : 8'hFF;
            end else if (wb_ready) begin
                wb_valid_reg  <= 1'b0;
            end
        end
    end

    assign add_opsel = add_opsel_reg;
    assign add_sew   = add_sew_reg;
    assign add_carry = add_carry_reg;
    assign rd_idx    = issue_cnt_reg;
    assign wb_valid  = wb_valid_reg;
    assign wb_idx    = wb_idx_reg;
    assign wb_be     = wb_be_reg;

endmodule

// File: tb/tb_vadd_seq_ctrl.sv
// Self-checking bench for vadd_seq_ctrl: directed vector table, a mid-instruction
// reset sequence and randomized instructions against a beat-list reference model.
module tb_vadd_seq_ctrl;

    localparam int VW = 8;
    localparam int SW = 2;
    localparam int OW = 6;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] in_opsel = '0;
    logic [SW-1:0] in_sew = '0;
    logic [VW-1:0] in_vl = '0;
    logic          in_carry = 1'b0;
    logic [OW-1:0] add_opsel;
    logic [SW-1:0] add_sew;
    logic          add_carry;
    logic          rd_en;
    logic [IW-1:0] rd_idx;
    logic          wb_valid;
    logic          wb_ready = 1'b1;
    logic [IW-1:0] wb_idx;
    logic [7:0]    wb_be;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    vadd_seq_ctrl #(
        .VL_WIDTH(VW), .SEW_WIDTH(SW), .OPSEL_WIDTH(OW), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opsel(in_opsel), .in_sew(in_sew), .in_vl(in_vl), .in_carry(in_carry),
        .add_opsel(add_opsel), .add_sew(add_sew), .add_carry(add_carry),
        .rd_en(rd_en), .rd_idx(rd_idx),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_be(wb_be),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_busy"},     int'(busy), 0);
        chk({tag, "_done"},     int'(done), 0);
        chk({tag, "_rd_en"},    int'(rd_en), 0);
        chk({tag, "_wb_valid"}, int'(wb_valid), 0);
        chk({tag, "_rd_idx"},   int'(rd_idx), 0);
        chk({tag, "_wb_idx"},   int'(wb_idx), 0);
        chk({tag, "_wb_be"},    int'(wb_be), 0);
        chk({tag, "_opsel"},    int'(add_opsel), 0);
        chk({tag, "_sew"},      int'(add_sew), 0);
        chk({tag, "_carry"},    int'(add_carry), 0);
    endtask

    // mode 0: wb_ready always high; 1: random backpressure; 2: 3-cycle stall on beat 5
    task automatic run_instr(input int vl, input int sew, input int opsel, input int carry,
                             input int mode, output int n_hs, output int last_be);
        int total, beats, tail, issued, hs, iter, budget, stall;
        bit last_prev, got_done;
        int exp_be[$];
        total = vl << sew;
        beats = (total + 7) / 8;
        tail  = total % 8;
        for (int i = 0; i < beats; i++)
            exp_be.push_back((i == beats - 1 && tail != 0) ? ((1 << tail) - 1) : 'hFF);

        @(negedge clk);
        in_valid = 1'b1;
        in_vl    = VW'(vl);
        in_sew   = SW'(sew);
        in_opsel = OW'(opsel);
        in_carry = carry[0];
        wb_ready = 1'b1;
        #1;
        chk("accept_ready", int'(in_ready), 1);

        issued = 0; hs = 0; iter = 0; stall = 0; last_be = 0;
        last_prev = 1'b0; got_done = 1'b0;
        budget = beats * 8 + 20;
        while (!got_done && iter < budget) begin
            @(negedge clk);
            iter++;
            in_valid = 1'($urandom_range(0, 1));
            in_opsel = OW'($urandom);
            in_sew   = SW'($urandom);
            in_vl    = VW'($urandom);
            in_carry = 1'($urandom);
            case (mode)
                1: wb_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (wb_valid && wb_idx == 5 && stall < 3) begin
                        wb_ready = 1'b0;
                        stall++;
                    end else begin
                        wb_ready = 1'b1;
                    end
                end
                default: wb_ready = 1'b1;
            endcase
            #1;
            chk("add_opsel", int'(add_opsel), opsel);
            chk("add_sew",   int'(add_sew), sew);
            chk("add_carry", int'(add_carry), carry);
            chk("busy",      int'(busy), 1);
            chk("in_ready_busy", int'(in_ready), 0);
            chk("done", int'(done), int'((beats == 0) ? (iter == 1) : last_prev));
            chk("wb_valid", int'(wb_valid), int'(issued > hs));
            chk("rd_en", int'(rd_en), int'((issued < beats) && (!(issued > hs) || wb_ready)));
            if (rd_en) begin
                chk("rd_idx", int'(rd_idx), issued);
                issued++;
            end
            last_prev = 1'b0;
            if (wb_valid && wb_ready) begin
                chk("wb_idx", int'(wb_idx), hs);
                if (hs < beats) chk("wb_be", int'(wb_be), exp_be[hs]);
                last_be = int'(wb_be);
                hs++;
                if (hs == beats) last_prev = 1'b1;
            end
            if (done) got_done = 1'b1;
        end
        if (!got_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", iter);
        end

        @(negedge clk);
        in_valid = 1'b0;
        wb_ready = 1'b1;
        #1;
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_busy",     int'(busy), 0);
        chk("idle_done",     int'(done), 0);
        chk("idle_wb_valid", int'(wb_valid), 0);
        chk("idle_rd_en",    int'(rd_en), 0);
        n_hs = hs;
        $display("instr vl=%0d sew=%0d opsel=%0h carry=%0d mode=%0d beats=%0d handshakes=%0d cycles=%0d",
                 vl, sew, opsel, carry, mode, beats, hs, iter);
    endtask

    typedef struct {
        int vl;
        int sew;
        int opsel;
        int carry;
        int mode;
        int exp_beats;
        int exp_last_be;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n_hs, last_be;

        vecs[0] = '{vl: 16,  sew: 0, opsel: 'h11, carry: 0, mode: 0, exp_beats: 2,   exp_last_be: 'hFF};
        vecs[1] = '{vl: 5,   sew: 1, opsel: 'h05, carry: 0, mode: 0, exp_beats: 2,   exp_last_be: 'h03};
        vecs[2] = '{vl: 3,   sew: 2, opsel: 'h2A, carry: 1, mode: 0, exp_beats: 2,   exp_last_be: 'h0F};
        vecs[3] = '{vl: 0,   sew: 2, opsel: 'h3F, carry: 1, mode: 0, exp_beats: 0,   exp_last_be: 0};
        vecs[4] = '{vl: 32,  sew: 3, opsel: 'h02, carry: 1, mode: 2, exp_beats: 32,  exp_last_be: 'hFF};
        vecs[5] = '{vl: 1,   sew: 0, opsel: 'h01, carry: 0, mode: 0, exp_beats: 1,   exp_last_be: 'h01};
        vecs[6] = '{vl: 7,   sew: 0, opsel: 'h07, carry: 1, mode: 1, exp_beats: 1,   exp_last_be: 'h7F};
        vecs[7] = '{vl: 255, sew: 3, opsel: 'h15, carry: 0, mode: 1, exp_beats: 255, exp_last_be: 'hFF};
        vecs[8] = '{vl: 13,  sew: 1, opsel: 'h33, carry: 1, mode: 1, exp_beats: 4,   exp_last_be: 'h03};

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 9; v++) begin
            run_instr(vecs[v].vl, vecs[v].sew, vecs[v].opsel, vecs[v].carry, vecs[v].mode,
                      n_hs, last_be);
            chk($sformatf("vec%0d_beats", v), n_hs, vecs[v].exp_beats);
            if (vecs[v].exp_beats != 0)
                chk($sformatf("vec%0d_last_be", v), last_be, vecs[v].exp_last_be);
        end

        // Reset while RUN with beat 3 of 8 on the writeback port.
        @(negedge clk);
        in_valid = 1'b1;
        in_vl    = 8'd64;
        in_sew   = 2'd0;
        in_opsel = 6'h09;
        in_carry = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_wb_idx", int'(wb_idx), 3);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        #1;
        chk("mid_rst_no_done", int'(done), 0);
        rst = 1'b1;
        run_instr(8, 0, 'h0C, 0, 0, n_hs, last_be);
        chk("post_rst_beats", n_hs, 1);
        chk("post_rst_be", last_be, 'hFF);

        for (int r = 0; r < 25; r++) begin
            run_instr($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 63),
                      $urandom_range(0, 1), $urandom_range(0, 2), n_hs, last_be);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
